// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, keeps one imem request in
// flight, holds the fetched word for ID and applies EX redirects.
module fetch_ctrl #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] PCF,
    output logic            if_valid,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc,
    output logic [XLEN-1:0] if_pcplus4
);

    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    // FETCH: may issue; WAIT: live request; HOLD: word held for ID;
    // DRAIN: request outstanding but its response is stale.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pcf_q, pcf_d;
    logic            if_valid_q, if_valid_d;
    logic [31:0]     if_instr_q, if_instr_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [XLEN-1:0] if_pcplus4_q, if_pcplus4_d;
    logic [XLEN-1:0] redirect_tgt;

    // Redirect targets are always word aligned.
    assign redirect_tgt = redirect_pc & ALIGN_MASK;

    // Request strobe depends only on state, redirect and reset.
    assign imem_req   = (state_q == S_FETCH) && !redirect_valid && !reset;
    assign imem_addr  = pcf_q;
    assign PCF        = pcf_q;
    assign if_valid   = if_valid_q;
    assign if_instr   = if_instr_q;
    assign if_pc      = if_pc_q;
    assign if_pcplus4 = if_pcplus4_q;

    // Next-state and datapath: redirect beats response / ID accept.
    always_comb begin
        state_d      = state_q;
        pcf_d        = pcf_q;
        if_valid_d   = if_valid_q;
        if_instr_d   = if_instr_q;
        if_pc_d      = if_pc_q;
        if_pcplus4_d = if_pcplus4_q;
        case (state_q)
            S_FETCH: begin
                if (redirect_valid) begin
                    pcf_d = redirect_tgt;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pcf_d   = redirect_tgt;
                    state_d = imem_rvalid ? S_FETCH : S_DRAIN;
                end else if (imem_rvalid) begin
                    if_instr_d   = imem_rdata;
                    if_pc_d      = pcf_q;
                    if_pcplus4_d = pcf_q + PC_STEP;
                    if_valid_d   = 1'b1;
                    state_d      = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    if_valid_d = 1'b0;
                    pcf_d      = redirect_tgt;
                    state_d    = S_FETCH;
                end else if (id_ready) begin
                    if_valid_d = 1'b0;
                    pcf_d      = pcf_q + PC_STEP;
                    state_d    = S_FETCH;
                end
            end
            S_DRAIN: begin
                if (redirect_valid) begin
                    pcf_d = redirect_tgt;
                end
                if (imem_rvalid) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pcf_q        <= RESET_PC & ALIGN_MASK;
            if_valid_q   <= 1'b0;
            if_instr_q   <= '0;
            if_pc_q      <= '0;
            if_pcplus4_q <= '0;
        end else begin
            state_q      <= state_d;
            pcf_q        <= pcf_d;
            if_valid_q   <= if_valid_d;
            if_instr_q   <= if_instr_d;
            if_pc_q      <= if_pc_d;
            if_pcplus4_q <= if_pcplus4_d;
        end
    end

endmodule
